uart_tx_apb_fifo: RTL
=====================

UART_TX_APB_FIFO -- requirements
Module: uart_tx_apb_fifo

Interface
REQ-001 SHALL have parameters (name, default, meaning): CLKS_PER_BIT, 8, pclk cycles per serial bit, >=2.
REQ-002 SHALL have parameter DATA_BITS, 8, data bits per frame, legal range 5..8.
REQ-003 SHALL have parameter FIFO_DEPTH, 8, TX FIFO entries, a power of 2, >=2.
REQ-004 SHALL have ports (name, direction, width, meaning):
- pclk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  APB slave select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- padd  in  32  byte address; only bits [3:2] are decoded.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  held at 1 (zero wait states).
- pslverr  out  1  error flag for the access phase.
- o_tx_serial  out  1  serial line, idle high.
- o_tx_done  out  1  one-cycle pulse per completed frame.
- o_tx_busy  out  1  1 whenever the FSM is not in IDLE.

Function
REQ-005 SHALL treat an access as psel=1 and penable=1; the setup phase has no side effects.
REQ-006 SHALL decode three registers:
- 0x0 TXDATA (write-only): push pwdata[DATA_BITS-1:0] into the FIFO.
- 0x4 CTRL (R/W): bit0 parity_en, bit1 parity_odd, bit2 two_stop.
- 0x8 STATUS (read-only): bit0 empty, bit1 full, bit2 busy, bits[15:8] FIFO level.
REQ-007 SHALL drive prdata combinationally during a read access, and return 0 for a write access or an unmapped address.
REQ-008 SHALL, on a TXDATA write while the FIFO is full, drop the data and assert pslverr for that access; the full check uses the pre-pop state even if a pop occurs in the same cycle.
REQ-009 SHALL ignore writes to STATUS and to unmapped addresses, with pslverr=0.
REQ-010 SHALL use an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL hold every bit for exactly CLKS_PER_BIT cycles, timed by a per-bit counter.
REQ-012 SHALL, in IDLE with the FIFO non-empty, pop one entry, latch the CTRL bits for that frame, enter START and drive o_tx_serial=0 from that edge.
- A push at edge E0 into an empty FIFO gives start bit low from edge E1.
REQ-013 SHALL transmit in DATA the LSB first, DATA_BITS bits in total.
REQ-014 SHALL, after DATA, go to PARITY if parity_en else STOP.
- The parity bit is the XOR of the data bits, inverted when parity_odd=1.
REQ-015 SHALL drive 1 in STOP for 1 bit time, or 2 bit times if two_stop.
REQ-016 SHALL pulse o_tx_done on the last cycle of STOP.
REQ-017 SHALL, at the end of STOP, go directly to START (with a pop) if the FIFO is non-empty, otherwise to IDLE; there is no idle gap between back-to-back frames.
REQ-018 SHALL, when a CTRL write occurs mid-frame, apply it only from the next frame start.
REQ-019 SHALL support simultaneous push and pop when the FIFO is not full; the level is then unchanged.
REQ-020 SHALL give a frame length in cycles of (1 + DATA_BITS + parity_en + 1 + two_stop) * CLKS_PER_BIT.

Reset
REQ-021 SHALL, on rst at any edge including mid-frame, set: FSM = IDLE, FIFO flushed (level 0), CTRL = 0, o_tx_serial = 1, o_tx_done = 0, o_tx_busy = 0, pslverr = 0, counters = 0.
REQ-022 SHALL hold pready at 1 during and after reset.

Structure
REQ-023 SHALL place the register offsets (0x0/0x4/0x8), the CTRL bit positions and the FSM state encoding in shared package uart_pkg.
REQ-024 SHALL implement the FIFO as sub-module uart_tx_fifo.
- Parameters WIDTH and DEPTH.
- Ports push, pop, din, dout, full, empty, level.
- dout is valid while empty=0.

Verification
REQ-025 SHALL cover, with CLKS_PER_BIT=4 and DATA_BITS=8: CTRL=0, write TXDATA=0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; o_tx_done pulses at cycle 40.
REQ-026 SHALL cover: CTRL=0x1, write 0xA5 -> parity bit 0, frame 44 cycles; CTRL=0x3, write 0xA5 -> parity bit 1.
REQ-027 SHALL cover: CTRL=0x4, write 0x00 then 0xFF back-to-back -> two frames of 44 cycles each, no idle gap, two o_tx_done pulses 44 cycles apart.
REQ-028 SHALL cover: 9 writes with FIFO_DEPTH=8 while one frame is in flight -> the 9th write sees pslverr=1 only if the FIFO is full; STATUS reads full=1, level=8.
REQ-029 SHALL cover: rst asserted during DATA of a 0x55 frame -> o_tx_serial=1 and STATUS reads 0x01 on the next cycle; no o_tx_done pulse.
REQ-030 SHALL cover: CTRL write 0x1 mid-frame -> the current frame has no parity bit and the next frame carries one.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART transmitter: register offsets, CTRL bit
// positions and the transmit FSM state encoding.
package uart_pkg;

  // Byte offsets; only address bits [3:2] take part in decoding.
  localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL   = 32'h0000_0004;
  localparam logic [31:0] REG_STATUS = 32'h0000_0008;

  localparam int unsigned CTRL_PARITY_EN  = 0;
  localparam int unsigned CTRL_PARITY_ODD = 1;
  localparam int unsigned CTRL_TWO_STOP   = 2;
  localparam int unsigned CTRL_WIDTH      = 3;

  localparam int unsigned STATUS_EMPTY    = 0;
  localparam int unsigned STATUS_FULL     = 1;
  localparam int unsigned STATUS_BUSY     = 2;
  localparam int unsigned STATUS_LEVEL_LO = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Register index selected by a byte address.
  function automatic logic [1:0] reg_index(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for transmit bytes; dout presents the head entry whenever
// empty is low. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LEVEL_FULL);
  assign empty     = (r_level == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/uart_tx_apb_fifo.sv
// APB-programmable UART transmitter: TXDATA pushes into a FIFO, CTRL selects
// parity and stop bits per frame, STATUS reports FIFO and line state.
module uart_tx_apb_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] padd,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        o_tx_serial,
  output logic        o_tx_done,
  output logic        o_tx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                  w_access;
  logic                  w_wr_access;
  logic                  w_rd_access;
  logic                  w_sel_txdata;
  logic                  w_sel_ctrl;
  logic                  w_sel_status;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_BITS-1:0]  w_fifo_dout;
  logic [LVL_W-1:0]      w_fifo_level;
  logic                  w_bit_end;
  logic                  w_last_stop;
  logic                  w_unused;

  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic [CTRL_WIDTH-1:0] r_frame_ctrl;
  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;

  // APB decode; only the access phase has side effects.
  assign w_access     = psel && penable;
  assign w_wr_access  = w_access && pwrite;
  assign w_rd_access  = w_access && !pwrite;
  assign w_sel_txdata = (reg_index(padd) == reg_index(REG_TXDATA));
  assign w_sel_ctrl   = (reg_index(padd) == reg_index(REG_CTRL));
  assign w_sel_status = (reg_index(padd) == reg_index(REG_STATUS));

  // Overflow is judged on the registered (pre-pop) full flag.
  assign w_push  = w_wr_access && w_sel_txdata && !w_fifo_full;
  assign pslverr = w_wr_access && w_sel_txdata && w_fifo_full && !rst;
  assign pready  = 1'b1;

  assign w_unused = ^{padd[31:4], padd[1:0], pwdata[31:DATA_BITS]};

  always_comb begin
    prdata = '0;
    if (w_rd_access) begin
      if (w_sel_ctrl) begin
        prdata[CTRL_WIDTH-1:0] = r_ctrl;
      end else if (w_sel_status) begin
        prdata[STATUS_EMPTY]                       = w_fifo_empty;
        prdata[STATUS_FULL]                        = w_fifo_full;
        prdata[STATUS_BUSY]                        = o_tx_busy;
        prdata[STATUS_LEVEL_LO+7:STATUS_LEVEL_LO]  = 8'(w_fifo_level);
      end
    end
  end

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (pwdata[DATA_BITS-1:0]),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (w_fifo_level)
  );

  assign w_bit_end   = (r_cnt == CNT_LAST);
  // r_idx counts stop bits while in STOP; the second one is last when two_stop.
  assign w_last_stop = (r_state == ST_STOP) && w_bit_end &&
                       (!r_frame_ctrl[CTRL_TWO_STOP] || r_idx[0]);
  assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || w_last_stop);

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_ctrl       <= '0;
      r_frame_ctrl <= '0;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
    end else begin
      if (w_wr_access && w_sel_ctrl) begin
        r_ctrl <= pwdata[CTRL_WIDTH-1:0];
      end

      if (w_pop) begin
        // Frame start: CTRL is sampled here so mid-frame writes wait a frame.
        r_state      <= ST_START;
        r_cnt        <= '0;
        r_idx        <= '0;
        r_shift      <= w_fifo_dout;
        r_parity     <= (^w_fifo_dout) ^ r_ctrl[CTRL_PARITY_ODD];
        r_frame_ctrl <= r_ctrl;
      end else if (r_state != ST_IDLE) begin
        if (!w_bit_end) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
          case (r_state)
            ST_START: r_state <= ST_DATA;
            ST_DATA: begin
              if (r_idx == IDX_LAST) begin
                r_idx   <= '0;
                r_state <= r_frame_ctrl[CTRL_PARITY_EN] ? ST_PARITY : ST_STOP;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_shift <= r_shift >> 1;
              end
            end
            ST_PARITY: r_state <= ST_STOP;
            ST_STOP: begin
              if (w_last_stop) begin
                r_state <= ST_IDLE;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    o_tx_serial = 1'b1;
    case (r_state)
      ST_START:  o_tx_serial = 1'b0;
      ST_DATA:   o_tx_serial = r_shift[0];
      ST_PARITY: o_tx_serial = r_parity;
      default:   o_tx_serial = 1'b1;
    endcase
  end

  assign o_tx_done = w_last_stop;
  assign o_tx_busy = (r_state != ST_IDLE);

endmodule
